// File: rtl/ntt_stream_deserializer_if.sv
// ----------------------------------------------------------------------------
// ntt_stream_deserializer_if
//
// Purpose:
//   Bundles the serial input handshake and the parallel vector output
//   handshake of the NTT stream deserializer into one interface.
//
// Parameters:
//   DATA_WIDTH_PER_INPUT : coefficient width in bits (W)
//   INPUT_PER_CYCLE      : lanes per parallel vector (P)
//
// Signals:
//   s_valid   serial word valid                     (producer -> deserializer)
//   s_ready   serial word accepted when both high   (deserializer -> producer)
//   s_data    serial coefficient, W bits            (producer -> deserializer)
//   s_last    final coefficient of a polynomial     (producer -> deserializer)
//   m_valid   parallel vector valid                 (deserializer -> consumer)
//   m_ready   consumer accepts vector               (consumer -> deserializer)
//   m_data    packed vector, lane k at [k*W +: W]   (deserializer -> consumer)
//   m_start   first vector of a frame               (deserializer -> consumer)
//   m_last    final vector of a frame               (deserializer -> consumer)
//   err_frame one-cycle framing violation pulse     (deserializer -> consumer)
//
// Modports:
//   slave  : the deserializer's view
//   master : the environment's view (stream producer plus vector consumer)
// ----------------------------------------------------------------------------
interface ntt_stream_deserializer_if #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 32
);

    logic                                            s_valid;
    logic                                            s_ready;
    logic [DATA_WIDTH_PER_INPUT-1:0]                 s_data;
    logic                                            s_last;
    logic                                            m_valid;
    logic                                            m_ready;
    logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] m_data;
    logic                                            m_start;
    logic                                            m_last;
    logic                                            err_frame;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_start,
        output m_last,
        output err_frame
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_start,
        input  m_last,
        input  err_frame
    );

endinterface

// File: rtl/ntt_stream_deserializer.sv
// ----------------------------------------------------------------------------
// ntt_stream_deserializer
//
// Purpose:
//   Receive side of the narrow-IO path into the NTT core. Packs a serial
//   stream of one coefficient per cycle into INPUT_PER_CYCLE-lane vectors and
//   presents them with valid/ready plus frame start/last markers. A frame is
//   VECTORS_PER_FRAME vectors long. Early or missing s_last markers are
//   reported on err_frame and the frame is closed regardless.
//
//   Storage is one fill buffer plus one output register. When a vector
//   completes while the output register is still occupied, the fill buffer
//   itself holds the finished vector (pend) and the serial side stalls until
//   the output register frees up.
//
// Parameters:
//   DATA_WIDTH_PER_INPUT : coefficient width W
//   INPUT_PER_CYCLE      : lanes per vector P (power of two, >= 2)
//   VECTORS_PER_FRAME    : vectors per polynomial V (power of two, >= 1)
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : ntt_stream_deserializer_if.slave (serial in, vector out, err_frame)
//
// Configuration macro:
//   NTT_DESER_BITREV_EN : when defined, the k-th word of a vector is written
//                         to lane bitrev(k) over log2(P) bits instead of
//                         lane k. Timing is identical in both builds.
// ----------------------------------------------------------------------------
module ntt_stream_deserializer #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 32,
    parameter int VECTORS_PER_FRAME    = 128
) (
    input logic                       clk,
    input logic                       rst,
    ntt_stream_deserializer_if.slave  bus
);

    localparam int W  = DATA_WIDTH_PER_INPUT;
    localparam int P  = INPUT_PER_CYCLE;
    localparam int V  = VECTORS_PER_FRAME;
    localparam int LW = $clog2(P);
    localparam int VW = (V > 1) ? $clog2(V) : 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);
    localparam logic [VW-1:0] VEC_LAST  = VW'(V - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LW-1:0]         r_laneCnt;
    logic [VW-1:0]         r_vecCnt;
    logic [P-1:0][W-1:0]   r_fill;
    logic                  r_pend;
    logic                  r_pendStart;
    logic                  r_pendLast;
    logic [P-1:0][W-1:0]   r_mData;
    logic                  r_mValid;
    logic                  r_mStart;
    logic                  r_mLast;
    logic                  r_errFrame;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_sReady;
    logic                  w_accept;
    logic                  w_laneEnd;
    logic                  w_vecEnd;
    logic                  w_complete;
    logic                  w_isStart;
    logic                  w_isLast;
    logic                  w_err;
    logic                  w_outFree;
    logic [LW-1:0]         w_laneIdx;
    logic [P-1:0][W-1:0]   w_fillNext;

    // Ready depends only on registered state (and reset), never on m_ready.
    assign w_sReady   = ~r_pend & ~rst;
    assign w_accept   = bus.s_valid & w_sReady;

    assign w_laneEnd  = (r_laneCnt == LANE_LAST);
    assign w_vecEnd   = (r_vecCnt == VEC_LAST);

    // A vector closes on its last lane or on any s_last (early last).
    assign w_complete = w_accept & (w_laneEnd | bus.s_last);
    assign w_isStart  = (r_vecCnt == '0);
    assign w_isLast   = bus.s_last | w_vecEnd;

    // s_last is legal only on lane P-1 of vector V-1, and that exact word
    // must carry it; any other combination is a framing violation.
    assign w_err      = w_accept & (bus.s_last ? ~(w_laneEnd & w_vecEnd)
                                               :  (w_laneEnd & w_vecEnd));

    assign w_outFree  = ~r_mValid | bus.m_ready;

`ifdef NTT_DESER_BITREV_EN
    // Bit-reversed lane placement: word k lands in lane bitrev(k).
    function automatic logic [LW-1:0] f_bitrev(input logic [LW-1:0] v);
        logic [LW-1:0] res;
        res = '0;
        for (int b = 0; b < LW; b++) begin
            res[b] = v[LW-1-b];
        end
        return res;
    endfunction

    assign w_laneIdx = f_bitrev(r_laneCnt);
`else
    // Natural lane placement: word k lands in lane k.
    assign w_laneIdx = r_laneCnt;
`endif

    // Fill buffer contents including the word being accepted this cycle, so a
    // completing word can go straight into the output register.
    always_comb begin
        w_fillNext            = r_fill;
        w_fillNext[w_laneIdx] = bus.s_data;
    end

    // ------------------------------------------------------------------
    // Fill side: lane/vector counters, fill buffer and the pend slot.
    // The buffer is cleared whenever its contents leave, which is what makes
    // unwritten lanes of an early-terminated vector read as zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_laneCnt   <= '0;
            r_vecCnt    <= '0;
            r_fill      <= '0;
            r_pend      <= 1'b0;
            r_pendStart <= 1'b0;
            r_pendLast  <= 1'b0;
            r_errFrame  <= 1'b0;
        end else begin
            r_errFrame <= w_err;
            if (w_accept) begin
                if (w_complete) begin
                    r_laneCnt <= '0;
                    r_vecCnt  <= w_isLast ? '0 : r_vecCnt + VW'(1);
                    if (w_outFree) begin
                        r_fill <= '0;
                    end else begin
                        r_fill      <= w_fillNext;
                        r_pend      <= 1'b1;
                        r_pendStart <= w_isStart;
                        r_pendLast  <= w_isLast;
                    end
                end else begin
                    r_laneCnt <= r_laneCnt + LW'(1);
                    r_fill    <= w_fillNext;
                end
            end else if (r_pend && w_outFree) begin
                r_fill <= '0;
                r_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register. A pending vector has priority; it cannot coincide
    // with a fresh completion because s_ready is low while pend is set.
    // A drain and a new completion in the same cycle reload directly, so
    // there is no bubble at full rate.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mData  <= '0;
            r_mValid <= 1'b0;
            r_mStart <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (r_pend && w_outFree) begin
            r_mData  <= r_fill;
            r_mValid <= 1'b1;
            r_mStart <= r_pendStart;
            r_mLast  <= r_pendLast;
        end else if (w_complete && w_outFree) begin
            r_mData  <= w_fillNext;
            r_mValid <= 1'b1;
            r_mStart <= w_isStart;
            r_mLast  <= w_isLast;
        end else if (bus.m_ready) begin
            r_mValid <= 1'b0;
            r_mStart <= 1'b0;
            r_mLast  <= 1'b0;
        end
    end

    assign bus.s_ready   = w_sReady;
    assign bus.m_valid   = r_mValid;
    assign bus.m_data    = r_mData;
    assign bus.m_start   = r_mStart;
    assign bus.m_last    = r_mLast;
    assign bus.err_frame = r_errFrame;

endmodule

// File: doc/ntt_stream_deserializer.md
Name: ntt_stream_deserializer

Overview:
- Receive side of the narrow-IO path into the NTT core: packs a serial stream of one coefficient per cycle into full INPUT_PER_CYCLE-lane vectors.
- Presents each vector to NTT_Top's parallel inData with valid/ready and frame markers.
- Counterpart of the serializing output path: lane k of each vector is the k-th accepted word.
- A frame of VECTORS_PER_FRAME vectors (4096 coefficients by default) carries a start marker on its first vector and a last marker on its final vector.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, coefficient width in bits.
- INPUT_PER_CYCLE, 32, lanes per parallel vector (P); power of two, >= 2.
- VECTORS_PER_FRAME, 128, vectors per polynomial (V); power of two, >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  serial word valid.
- s_ready  out  1  serial word accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH_PER_INPUT  serial coefficient.
- s_last  in  1  marks final coefficient of a polynomial.
- m_valid  out  1  parallel vector valid.
- m_ready  in  1  consumer accepts vector when m_valid && m_ready.
- m_data  out  P*DATA_WIDTH_PER_INPUT  packed vector; lane k at bits [k*W +: W].
- m_start  out  1  vector is first of a frame; qualified by m_valid.
- m_last  out  1  vector is final of a frame; qualified by m_valid.
- err_frame  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: lane_cnt=0, vec_cnt=0, pend=0, m_valid=0, m_start=0, m_last=0, err_frame=0, m_data=0, fill buffer cleared. s_ready=0 while rst is high and 1 in the first cycle after.
- Reset mid-operation: discards any partial vector, pending vector and presented vector. No output beat is emitted for them.
- Storage: one fill buffer (P lanes) plus one output register. A pend flag marks a completed fill buffer that is waiting for the output register.
- s_ready = !pend (registered state, no combinational path from m_ready).
- Accept: word goes to fill lane lane_cnt; lane_cnt increments.
- Vector completes on an accepted word when lane_cnt==P-1, or when s_last=1 (early last).
- Output register is "free" when m_valid==0 || m_ready==1.
- Completion with register free: the output register loads next edge, m_valid=1 one cycle after the last word is accepted (latency 1).
- Completion with register busy: pend=1 and s_ready drops next cycle. Transfer happens on the first cycle the register is free; then pend clears.
- Simultaneous events: register drain and new completion in the same cycle load directly with no bubble. Sustained throughput is 1 word/cycle with m_ready held at 1.
- Fill buffer restarts at lane 0 the cycle after completion. Lanes of a completed vector not written in that vector are 0.
- Framing counters:
  - vec_cnt increments per completed vector.
  - m_start = (vec_cnt==0 at completion).
  - m_last = s_last on the completing word, or vec_cnt==V-1.
  - After an m_last vector, vec_cnt=0.
- Framing errors (err_frame pulses the cycle after the offending word is accepted):
  - s_last with lane_cnt!=P-1 or vec_cnt!=V-1: early last. Remaining lanes are zero-padded, the vector is marked m_last, and the frame resets.
  - Lane P-1 of vector V-1 accepted with s_last=0: missing last. The vector is still marked m_last and counters wrap.
- m_data, m_start, m_last stay stable while m_valid && !m_ready.

Optional Feature:
- Macro: NTT_DESER_BITREV_EN.
- Defined: the k-th word of a vector is written to lane bitrev(k) over log2(P) bits. Zero padding still applies to lanes never written. All timing is unchanged.
- Undefined: natural order, word k to lane k.

Test Plan (P=4, V=2, W=28 unless stated):
- Streaming: send words 1..8, s_last on 8, m_ready=1.
  - Required: vector {1,2,3,4} with m_start=1, m_last=0, m_valid one cycle after word 4.
  - Required: vector {5,6,7,8} with m_start=0, m_last=1; err_frame never pulses.
- Backpressure: m_ready=0, send words 1..8.
  - Required: s_ready drops after word 8; first vector {1,2,3,4} held stable.
  - On m_ready=1: vector {5,6,7,8} follows on the next cycle; s_ready returns to 1.
- Early last: send 1,2,3 with s_last on 3.
  - Required: vector {1,2,3,0}, m_start=1, m_last=1, err_frame pulse.
  - The next word starts a new frame (m_start=1).
- Missing last: send 1..8, s_last=0 on all.
  - Required: second vector m_last=1, err_frame pulse after word 8, then a new frame.
- Reset mid-vector: send 1,2, assert rst for 1 cycle, then send 9..12.
  - Required: a single vector {9,10,11,12} with m_start=1; no output containing 1 or 2.
- With NTT_DESER_BITREV_EN: send 1..4.
  - Required: m_data lanes {1,3,2,4}.
